hack_boot_loader: RTL and testbench

Boot sequencer for the Hack system: parses a byte stream from the UART receiver, writes program words into instruction ROM through the loader port (`o_pc_loader`, `o_rom`, `o_Bus_CS`), verifies an 8-bit checksum, then switches the system from boot to run mode and releases the CPU from reset. It owns the boot/run mode bit and the CPU reset, and is the only writer of ROM.

---
 rtl/hack_boot_loader.sv | 189 ++++++++++++++++++
 tb/tb_hack_boot_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_boot_loader.sv
// rtl/hack_boot_loader.sv - Hack boot sequencer: UART frame parser, ROM loader, checksum, boot/run handoff
//
// Frame: 0xA5, LEN_HI, LEN_LO, N x (HI, LO), CSUM. CSUM is the 8-bit sum of every
// byte between the sync byte and CSUM. On success the system enters run mode and
// the CPU is released from reset RESET_CYCLES cycles later.
//
// Ports:
//   CLK            in   system clock, rising edge
//   i_reset_n      in   asynchronous active-low reset
//   i_rx_dv        in   one-cycle strobe, i_rx_byte valid
//   i_rx_byte      in   received byte
//   i_start        in   one-cycle pulse, return to IDLE (wins over i_rx_dv)
//   o_pc_loader    out  ROM write address (0-based word index)
//   o_rom          out  ROM write data
//   o_Bus_CS       out  one-cycle ROM write strobe
//   o_mode         out  0 = boot, 1 = run
//   o_cpu_reset    out  active-high CPU reset
//   o_busy         out  frame in progress (LEN_HI..CSUM)
//   o_error        out  last frame failed, sticky until i_start or reset
//   o_words_loaded out  words written in current/last frame
module hack_boot_loader #(
    parameter int ROM_DEPTH      = 1001,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RESET_CYCLES   = 4
) (
    input  logic        CLK,
    input  logic        i_reset_n,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_start,
    output logic [15:0] o_pc_loader,
    output logic [15:0] o_rom,
    output logic        o_Bus_CS,
    output logic        o_mode,
    output logic        o_cpu_reset,
    output logic        o_busy,
    output logic        o_error,
    output logic [15:0] o_words_loaded
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM,
        S_RESET_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t         state;
    state_t         next_state;
    logic           take;
    logic           busy_now;
    logic           timeout_hit;
    logic           wr;
    logic [15:0]    len_cand;
    logic [TW-1:0]  tcnt;
    logic [HW-1:0]  hcnt;
    logic [7:0]     sum;
    logic [7:0]     len_hi;
    logic [7:0]     data_hi;
    logic [15:0]    len;
    logic [15:0]    idx;

    // A byte coinciding with i_start is dropped.
    assign take     = i_rx_dv && !i_start;
    assign len_cand = {len_hi, i_rx_byte};
    assign busy_now = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA_HI) ||
                      (state == S_DATA_LO) || (state == S_CSUM);
    assign timeout_hit = busy_now && !take && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        next_state = state;
        wr         = 1'b0;
        if (i_start) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (take && i_rx_byte == SYNC) next_state = S_LEN_HI;
                S_LEN_HI: if (take) next_state = S_LEN_LO;
                S_LEN_LO: begin
                    if (take) begin
                        if (len_cand == 16'd0)
                            next_state = S_CSUM;
                        else if ({16'd0, len_cand} > 32'(ROM_DEPTH))
                            next_state = S_ERROR;
                        else
                            next_state = S_DATA_HI;
                    end
                end
                S_DATA_HI: if (take) next_state = S_DATA_LO;
                S_DATA_LO: begin
                    if (take) begin
                        wr         = 1'b1;
                        next_state = (idx + 16'd1 == len) ? S_CSUM : S_DATA_HI;
                    end
                end
                S_CSUM: if (take) next_state = (i_rx_byte == sum) ? S_RESET_HOLD : S_ERROR;
                S_RESET_HOLD: if (hcnt == HW'(RESET_CYCLES - 1)) next_state = S_RUN;
                S_RUN:   next_state = S_RUN;
                S_ERROR: next_state = S_ERROR;
                default: next_state = S_IDLE;
            endcase
            if (timeout_hit) next_state = S_ERROR;
        end
    end

    always_ff @(posedge CLK or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= S_IDLE;
            tcnt           <= '0;
            hcnt           <= '0;
            sum            <= 8'd0;
            len_hi         <= 8'd0;
            data_hi        <= 8'd0;
            len            <= 16'd0;
            idx            <= 16'd0;
            o_pc_loader    <= 16'd0;
            o_rom          <= 16'd0;
            o_Bus_CS       <= 1'b0;
            o_mode         <= 1'b0;
            o_cpu_reset    <= 1'b1;
            o_busy         <= 1'b0;
            o_error        <= 1'b0;
            o_words_loaded <= 16'd0;
        end else begin
            state <= next_state;

            // Inter-byte idle counter, only meaningful inside a frame.
            if (take || !busy_now) tcnt <= '0;
            else                   tcnt <= tcnt + TW'(1);

            // Counts cycles spent in RESET_HOLD; zero on entry.
            if (state == S_RESET_HOLD) hcnt <= hcnt + HW'(1);
            else                       hcnt <= '0;

            if (take) begin
                case (state)
                    S_IDLE: begin
                        if (i_rx_byte == SYNC) begin
                            sum            <= 8'd0;
                            idx            <= 16'd0;
                            o_words_loaded <= 16'd0;
                        end
                    end
                    S_LEN_HI: begin
                        len_hi <= i_rx_byte;
                        sum    <= sum + i_rx_byte;
                    end
                    S_LEN_LO: begin
                        len <= len_cand;
                        sum <= sum + i_rx_byte;
                    end
                    S_DATA_HI: begin
                        data_hi <= i_rx_byte;
                        sum     <= sum + i_rx_byte;
                    end
                    S_DATA_LO: begin
                        sum            <= sum + i_rx_byte;
                        idx            <= idx + 16'd1;
                        o_words_loaded <= idx + 16'd1;
                    end
                    default: ;
                endcase
            end

            o_Bus_CS <= wr;
            if (wr) begin
                o_pc_loader <= idx;
                o_rom       <= {data_hi, i_rx_byte};
            end

            o_mode      <= (next_state == S_RESET_HOLD) || (next_state == S_RUN);
            o_cpu_reset <= (next_state != S_RUN);
            o_error     <= (next_state == S_ERROR);
            o_busy      <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                           (next_state == S_DATA_HI) || (next_state == S_DATA_LO) ||
                           (next_state == S_CSUM);
        end
    end

endmodule

// File: tb/tb_hack_boot_loader.sv
// tb/tb_hack_boot_loader.sv - randomized self-checking bench for hack_boot_loader
module tb_hack_boot_loader;

    localparam int DEPTH = 1001;
    localparam int TMO   = 16;
    localparam int RCY   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        start;
    logic [15:0] pc_loader;
    logic [15:0] rom;
    logic        bus_cs;
    logic        mode;
    logic        cpu_reset;
    logic        busy;
    logic        error;
    logic [15:0] words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  fr[$];
    logic [31:0] cap[$];
    logic        prev_cs = 1'b0;

    hack_boot_loader #(.ROM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .RESET_CYCLES(RCY)) dut (
        .CLK(clk), .i_reset_n(rst_n), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte), .i_start(start),
        .o_pc_loader(pc_loader), .o_rom(rom), .o_Bus_CS(bus_cs), .o_mode(mode),
        .o_cpu_reset(cpu_reset), .o_busy(busy), .o_error(error), .o_words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Record every ROM write; a strobe must never last two cycles.
    always @(negedge clk) begin
        if (prev_cs) check("strobe_1cyc", {31'd0, bus_cs}, 32'd0);
        if (bus_cs) cap.push_back({pc_loader, rom});
        prev_cs = bus_cs;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        tick($urandom_range(0, maxgap));
        rx_dv = 1'b1;
        rx_byte = b;
        tick(1);
        rx_dv = 1'b0;
        rx_byte = $urandom_range(0, 255);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_mode", {31'd0, mode}, 32'd0);
        check("start_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("start_err", {31'd0, error}, 32'd0);
        check("start_busy", {31'd0, busy}, 32'd0);
        check("start_cs", {31'd0, bus_cs}, 32'd0);
    endtask

    // Frame generator: n words of random data, correct or corrupted checksum.
    task automatic build(input int n, input bit good);
        logic [7:0] s;
        logic [7:0] b;
        fr.delete();
        fr.push_back(8'hA5);
        fr.push_back(n[15:8]);
        fr.push_back(n[7:0]);
        if (n <= DEPTH) begin
            for (int i = 0; i < 2 * n; i++) begin
                b = $urandom_range(0, 255);
                fr.push_back(b);
            end
            s = 8'd0;
            for (int i = 1; i < fr.size(); i++) s = s + fr[i];
            fr.push_back(good ? s : s ^ 8'h01);
        end
    endtask

    // Reference model: derive the outcome of fr purely from the frame rules.
    task automatic run_frame(input int maxgap);
        int  n;
        int  nw;
        int  s;
        bit  ok;
        cap.delete();
        foreach (fr[i]) send(fr[i], maxgap);
        n = fr[1] * 256 + fr[2];
        if (n > DEPTH) begin
            nw = 0;
            ok = 1'b0;
        end else begin
            nw = n;
            s = 0;
            for (int i = 1; i < 3 + 2 * n; i++) s += fr[i];
            ok = (fr[3 + 2 * n] == s[7:0]);
        end
        check("n_writes", cap.size(), nw);
        for (int k = 0; k < nw && k < cap.size(); k++)
            check($sformatf("write%0d", k), cap[k], {k[15:0], fr[3 + 2 * k], fr[4 + 2 * k]});
        check("words_loaded", {16'd0, words_loaded}, nw);
        check("busy_end", {31'd0, busy}, 32'd0);
        if (ok) begin
            check("mode_run", {31'd0, mode}, 32'd1);
            check("err_ok", {31'd0, error}, 32'd0);
            check("cpurst_hold0", {31'd0, cpu_reset}, 32'd1);
            for (int k = 1; k <= RCY; k++) begin
                tick(1);
                check($sformatf("cpurst_hold%0d", k), {31'd0, cpu_reset}, (k < RCY) ? 32'd1 : 32'd0);
            end
            check("mode_run2", {31'd0, mode}, 32'd1);
        end else begin
            check("err_set", {31'd0, error}, 32'd1);
            check("mode_boot", {31'd0, mode}, 32'd0);
            check("cpurst_err", {31'd0, cpu_reset}, 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rx_dv = 1'b0;
        rx_byte = 8'd0;
        start = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_pc", {16'd0, pc_loader}, 32'd0);
        check("rst_rom", {16'd0, rom}, 32'd0);
        check("rst_cs", {31'd0, bus_cs}, 32'd0);
        check("rst_mode", {31'd0, mode}, 32'd0);
        check("rst_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, error}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);

        // Fixed two-word frame, good then bad checksum, back-to-back bytes.
        fr = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        run_frame(0);
        pulse_start();
        fr = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
        run_frame(2);
        pulse_start();

        // Empty frame and length boundaries.
        fr = {8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(1);
        pulse_start();
        build(DEPTH + 1, 1'b1);
        run_frame(1);
        pulse_start();
        build(DEPTH, 1'b1);
        run_frame(0);
        pulse_start();

        // Noise before sync, then a stalled frame.
        cap.delete();
        send(8'h00, 2);
        send(8'hFF, 2);
        check("noise_busy", {31'd0, busy}, 32'd0);
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        tick(TMO - 1);
        check("tmo_not_yet", {31'd0, error}, 32'd0);
        check("tmo_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("tmo_err", {31'd0, error}, 32'd1);
        check("tmo_mode", {31'd0, mode}, 32'd0);
        check("tmo_writes", cap.size(), 0);
        pulse_start();

        // Randomized frames with random gaps and random checksum corruption.
        for (int t = 0; t < 8; t++) begin
            build($urandom_range(1, 20), $urandom_range(0, 2) != 0);
            run_frame(3);
            pulse_start();
        end

        // In RUN, bytes are ignored; i_start beats a coincident sync byte.
        build(3, 1'b1);
        run_frame(1);
        send(8'hA5, 0);
        send(8'h00, 0);
        check("run_ignore_busy", {31'd0, busy}, 32'd0);
        check("run_ignore_mode", {31'd0, mode}, 32'd1);
        check("run_ignore_cpurst", {31'd0, cpu_reset}, 32'd0);
        start = 1'b1;
        rx_dv = 1'b1;
        rx_byte = 8'hA5;
        tick(1);
        start = 1'b0;
        rx_dv = 1'b0;
        check("coinc_mode", {31'd0, mode}, 32'd0);
        check("coinc_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("coinc_busy", {31'd0, busy}, 32'd0);
        send(8'h00, 0);
        check("coinc_dropped", {31'd0, busy}, 32'd0);
        build(2, 1'b1);
        run_frame(2);
        pulse_start();

        // Asynchronous reset after the DATA_HI byte.
        cap.delete();
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_cpurst", {31'd0, cpu_reset}, 32'd1);
        check("arst_mode", {31'd0, mode}, 32'd0);
        check("arst_words", {16'd0, words_loaded}, 32'd0);
        check("arst_cs", {31'd0, bus_cs}, 32'd0);
        tick(1);
        rx_dv = 1'b1;
        rx_byte = 8'h34;
        tick(1);
        rx_dv = 1'b0;
        rst_n = 1'b1;
        tick(2);
        check("arst_no_write", cap.size(), 0);
        check("arst_idle", {31'd0, busy}, 32'd0);
        build(4, 1'b1);
        run_frame(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
